// File: rtl/regfile_wb.sv
// Writeback-side register file: one write port, two combinational read ports, zero-sweep init FSM.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WR_BYPASS_EN.
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_done,
    output logic              stall_req
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_next;
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    logic              w_init_wr;
    logic              w_run_wr;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_idx   <= FIRST_IDX;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_init_wr    = 1'b0;
        w_run_wr     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_wr  = 1'b1;
                w_idx_next = r_idx + 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run_wr = we && (waddr != '0);
            end
            default: begin
                w_state_next = S_INIT;
                w_idx_next   = FIRST_IDX;
            end
        endcase
    end

    // Storage has no reset so it can map to plain flops/RAM. While rst is held the FSM
    // sits at idx=1 and may rewrite entry 1 with zero, which the sweep clears anyway.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_idx] <= '0;
        end else if (w_run_wr) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        if (r_state == S_RUN) begin
            if (re1 && (raddr1 != '0)) begin
`ifdef REGFILE_WR_BYPASS_EN
                w_rdata1 = (we && (waddr == raddr1)) ? wdata : r_mem[raddr1];
`else
                w_rdata1 = r_mem[raddr1];
`endif
            end
            if (re2 && (raddr2 != '0)) begin
`ifdef REGFILE_WR_BYPASS_EN
                w_rdata2 = (we && (waddr == raddr2)) ? wdata : r_mem[raddr2];
`else
                w_rdata2 = r_mem[raddr2];
`endif
            end
        end
    end

    assign rdata1    = w_rdata1;
    assign rdata2    = w_rdata2;
    assign init_done = (r_state == S_RUN);
    assign stall_req = (r_state == S_INIT);

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random traffic against a
// behavioural register-file model (busy-cycle counter plus an array of register values).
module tb_regfile_wb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              init_done;
    logic              stall_req;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining init cycles and architectural register values.
    int                m_busy = NUM_REGS - 1;
    logic [DATA_W-1:0] m_regs [NUM_REGS];

    regfile_wb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .init_done(init_done),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    end

    always @(negedge rst) begin
        m_busy = NUM_REGS - 1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    end

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            if (m_busy > 0) m_busy = m_busy - 1;
            else if (we && waddr != 0) m_regs[waddr] = wdata;
        end
    end

    function automatic logic [DATA_W-1:0] model_read(input logic r_en, input logic [ADDR_W-1:0] a);
        if (m_busy > 0 || !r_en || a == 0) return '0;
`ifdef REGFILE_WR_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return m_regs[a];
    endfunction

    task automatic wait_sweep(input string name);
        int cnt = 0;
        while (stall_req === 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt < NUM_REGS - 1) begin
                checks++;
                if (init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_init_done_low cycle %0d: got %b want 0", name, cnt, init_done);
                end
            end
        end
        checks++;
        if (cnt != NUM_REGS - 1) begin
            errors++;
            $display("FAIL %s_sweep_len: got %0d edges want %0d", name, cnt, NUM_REGS - 1);
        end
        checks++;
        if (init_done !== 1'b1 || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_run_flags: got init_done=%b stall_req=%b want 1/0", name, init_done, stall_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd17;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall_req !== 1'b1 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got stall_req=%b init_done=%b want 1/0", stall_req, init_done);
        end
        checks++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", rdata1, rdata2);
        end
        // Writes attempted throughout the sweep must be ignored.
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
        wait_sweep("init");
        @(negedge clk);
        we = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            @(negedge clk);
            re1 = 1'b1; raddr1 = ADDR_W'(a);
            re2 = 1'b1; raddr2 = ADDR_W'(NUM_REGS - 1 - a);
            #1;
            checks++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                errors++;
                $display("FAIL init_zero addr %0d: got %h/%h want 0/0", a, rdata1, rdata2);
            end
        end
        raddr1 = 5'd3;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL init_write_ignored: got %h want 0", rdata1);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read_p1: got %h want deadbeef", rdata1);
        end
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL write_read_p2_disabled: got %h want 0", rdata2);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; re1 = 1'b1; raddr1 = 5'd0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_same_cycle: got %h want 0", rdata1);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_next_cycle: got %h want 0", rdata1);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp_same;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
`ifdef REGFILE_WR_BYPASS_EN
        exp_same = 32'hCAFE_F00D;
`else
        exp_same = 32'h1111_1111;
`endif
        #1;
        checks++;
        if (rdata1 !== exp_same || rdata2 !== exp_same) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h/%h want %h", rdata1, rdata2, exp_same);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'hCAFE_F00D || rdata2 !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bypass_next_cycle: got %h/%h want cafef00d", rdata1, rdata2);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we    = ($urandom_range(0, 3) != 0);
            waddr = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            wdata = $urandom;
            re1   = ($urandom_range(0, 7) != 0);
            re2   = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, NUM_REGS - 1));
            #1;
            e1 = model_read(re1, raddr1);
            e2 = model_read(re2, raddr2);
            checks++;
            if (rdata1 !== e1 || rdata2 !== e2) begin
                errors++;
                $display("FAIL random_read it %0d a1=%0d a2=%0d: got %h/%h want %h/%h",
                         n, raddr1, raddr2, rdata1, rdata2, e1, e2);
            end
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL midrun_pre_write: got %h want a5a5a5a5", rdata1);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b1 || init_done !== 1'b0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL midrun_async: got stall_req=%b init_done=%b rdata1=%h want 1/0/0",
                     stall_req, init_done, rdata1);
        end
        #1 rst = 1'b1;
        wait_sweep("midrun");
        @(negedge clk);
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reg9_cleared: got %h want 0", rdata1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg0();
        test_bypass();
        test_random();
        test_midrun_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- General-purpose register file at the consuming end of the MEM/WB writeback interface.
- Accepts one writeback per cycle (wreg/wd/wdata from the WB pipeline register).
- Serves two combinational read ports to the ID stage.
- Storage array is not reset, so it can map to RAM-friendly flops. Instead, an init FSM sweeps zeros into every entry after reset and holds a stall request until the sweep is done.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of entries; must equal 2**ADDR_W. Entry 0 is hardwired to zero.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- we  input  1  writeback enable (from wb_wreg).
- waddr  input  ADDR_W  writeback address (from wb_wd).
- wdata  input  DATA_W  writeback data (from wb_wdata).
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).
- init_done  output  1  high once the zero sweep has completed.
- stall_req  output  1  pipeline hold request; high while initialising.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to INIT with sweep index idx=1.
  - init_done=0, stall_req=1.
  - Array contents are untouched.
- INIT state:
  - Each rising edge writes 0 to entry idx, then increments idx.
  - After the edge that writes entry NUM_REGS-1, the FSM moves to RUN. INIT therefore lasts NUM_REGS-1 cycles (31 by default).
  - External we is ignored throughout INIT; no array write occurs.
  - rdata1 and rdata2 read 0 regardless of re/raddr.
  - stall_req=1, init_done=0.
- RUN state:
  - init_done=1, stall_req=0.
  - Write: on a rising edge with we=1 and waddr!=0, entry[waddr] takes wdata.
  - Writes to address 0 are discarded.
- Reads in RUN (combinational, per port, priority order):
  1. re=0 → 0.
  2. raddr=0 → 0.
  3. Bypass hit (see Optional Feature) → wdata.
  4. Otherwise → entry[raddr].
- Both ports may read the same address in the same cycle; each independently returns the same value.
- rst asserted mid-INIT or mid-RUN:
  - FSM immediately returns to INIT with idx=1; outputs take their reset values at once.
  - Any write on that edge is not performed.
  - Array data is re-zeroed by the new sweep.
- Widths: idx is ADDR_W bits. The INIT→RUN transition is decided on idx==NUM_REGS-1, never on wrap to 0.
- No X may appear on rdata1/rdata2 in any state.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - In RUN, a read with re=1, raddr!=0, we=1 and waddr==raddr returns wdata in the same cycle (write-to-read forwarding). This resolves the WB→ID hazard.
  - The bypass applies on each port independently.
- Not defined:
  - That read returns the old entry[raddr]; the new value is visible from the next cycle.
  - Hazard resolution is then the pipeline's responsibility.
- With or without the macro, INIT-state reads are 0 and address 0 reads 0.

Test Plan:
- Init sweep: assert rst=0 for 3 cycles, release.
  - Required: stall_req=1 and init_done=0 for exactly 31 rising edges, then init_done=1 and stall_req=0.
  - Required: reading all 32 addresses returns 0x00000000.
- Write/read: in RUN, write waddr=5, wdata=0xDEADBEEF.
  - Required: next cycle, re1=1/raddr1=5 returns 0xDEADBEEF.
  - Required: re2=0/raddr2=5 returns 0.
- Register 0: write waddr=0, wdata=0x12345678.
  - Required: raddr1=0 returns 0 in both the same and the next cycle.
- Bypass: same cycle we=1, waddr=7, wdata=0xCAFEF00D, raddr1=raddr2=7 (reg7 previously 0x11111111).
  - With REGFILE_WR_BYPASS_EN: both ports return 0xCAFEF00D that cycle.
  - Without it: both return 0x11111111 that cycle, then 0xCAFEF00D next cycle.
- INIT write ignore: drive we=1, waddr=3, wdata=0xFFFFFFFF during INIT.
  - Required: after init_done, raddr1=3 returns 0.
- Mid-run reset: write reg9=0xA5A5A5A5, then pulse rst=0 asynchronously between edges.
  - Required: init_done and stall_req change immediately.
  - Required: after the new 31-cycle sweep, reg9 reads 0.
